// File: rtl/change_dispenser.sv
// change_dispenser: greedy quarter/dime/nickel dispenser with tube-empty fallback and paced pulses.
module change_dispenser #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] amount,
    input  logic        quarter_empty,
    input  logic        dime_empty,
    input  logic        nickel_empty,
    output logic        coin_quarter,
    output logic        coin_dime,
    output logic        coin_nickel,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] remaining,
    output logic [2:0]  residue,
    output logic [31:0] count_q,
    output logic [31:0] count_d,
    output logic [31:0] count_n
);
    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
    state_t      state;
    logic [31:0] gap_cnt;
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            coin_quarter <= 1'b0;
            coin_dime    <= 1'b0;
            coin_nickel  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            remaining    <= '0;
            residue      <= '0;
            count_q      <= '0;
            count_d      <= '0;
            count_n      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    remaining <= amount - (amount % 32'd5);
                    residue   <= 3'(amount % 32'd5);
                    count_q   <= '0;
                    count_d   <= '0;
                    count_n   <= '0;
                    error     <= 1'b0;
                    busy      <= 1'b1;
                    state     <= SELECT;
                end
                // remaining is always a nonzero multiple of 5 past the first test, so a nickel always fits
                SELECT: begin
                    if (remaining == 32'd0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (remaining >= 32'd25 && !quarter_empty) begin
                        coin_quarter <= 1'b1;
                        state        <= PULSE;
                    end else if (remaining >= 32'd10 && !dime_empty) begin
                        coin_dime <= 1'b1;
                        state     <= PULSE;
                    end else if (!nickel_empty) begin
                        coin_nickel <= 1'b1;
                        state       <= PULSE;
                    end else begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                PULSE: begin
                    remaining    <= remaining - (coin_quarter ? 32'd25 : coin_dime ? 32'd10 : 32'd5);
                    count_q      <= count_q + {31'd0, coin_quarter};
                    count_d      <= count_d + {31'd0, coin_dime};
                    count_n      <= count_n + {31'd0, coin_nickel};
                    coin_quarter <= 1'b0;
                    coin_dime    <= 1'b0;
                    coin_nickel  <= 1'b0;
                    gap_cnt      <= '0;
                    state        <= (GAP_CYCLES > 0) ? GAP : SELECT;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 32'd1;
                    if (gap_cnt == 32'(GAP_CYCLES - 1)) state <= SELECT;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized transactions checked cycle by cycle against a coin-schedule model.
module tb_change_dispenser;
    localparam int G = 2;
    localparam int P = 2 + G;
    logic        clock = 1'b0;
    logic        reset, start, quarter_empty, dime_empty, nickel_empty;
    logic [31:0] amount;
    logic        coin_quarter, coin_dime, coin_nickel, busy, done, error;
    logic [31:0] remaining, count_q, count_d, count_n;
    logic [2:0]  residue;
    int total = 0;
    int bad = 0;

    change_dispenser #(.GAP_CYCLES(G)) dut (
        .clock(clock), .reset(reset), .start(start), .amount(amount),
        .quarter_empty(quarter_empty), .dime_empty(dime_empty), .nickel_empty(nickel_empty),
        .coin_quarter(coin_quarter), .coin_dime(coin_dime), .coin_nickel(coin_nickel),
        .busy(busy), .done(done), .error(error), .remaining(remaining), .residue(residue),
        .count_q(count_q), .count_d(count_d), .count_n(count_n)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctl"}, {coin_quarter, coin_dime, coin_nickel, busy, done, error, residue}, 0);
        check({tag, " rem"}, remaining, 0);
        check({tag, " counts"}, {32'd0, count_q | count_d | count_n}, 0);
    endtask

    // Greedy coin list from the rules, then the timing follows: one coin every P cycles.
    task automatic run_txn(input int amt, input logic q, input logic d, input logic n, input bit glitch);
        int coins[$];
        int rem, cq, cd, cn, len, k, ec;
        bit err;
        rem = amt - amt % 5;
        err = 0; cq = 0; cd = 0; cn = 0;
        while (rem > 0) begin
            if (rem >= 25 && !q) begin coins.push_back(25); rem -= 25; cq++; end
            else if (rem >= 10 && !d) begin coins.push_back(10); rem -= 10; cd++; end
            else if (!n) begin coins.push_back(5); rem -= 5; cn++; end
            else begin err = 1; break; end
        end
        len = coins.size() * P + 2;
        @(negedge clock);
        start = 1'b1; amount = 32'(amt);
        quarter_empty = q; dime_empty = d; nickel_empty = n;
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clock);
            if (c == 1) start = 1'b0;
            k = (c - 2) / P;
            ec = (c >= 2 && (c - 2) % P == 0 && k < coins.size()) ? coins[k] : 0;
            check("coins", {coin_quarter, coin_dime, coin_nickel}, {ec == 25, ec == 10, ec == 5});
            check("done", done, c == len);
            check("busy", busy, c <= len);
            if (glitch) begin
                start = (c > 1 && c < len) ? ($urandom_range(0, 3) == 0) : 1'b0;
                amount = $urandom_range(0, 500);
            end
        end
        check("remaining", remaining, rem);
        check("residue", residue, amt % 5);
        check("count_q", count_q, cq);
        check("count_d", count_d, cd);
        check("count_n", count_n, cn);
        check("error", error, err);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; amount = '0;
        quarter_empty = 1'b0; dime_empty = 1'b0; nickel_empty = 1'b0;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        run_txn(40, 0, 0, 0, 0);
        run_txn(7, 0, 0, 0, 0);
        run_txn(50, 1, 0, 0, 0);
        run_txn(30, 1, 1, 1, 0);
        run_txn(0, 0, 0, 0, 0);
        run_txn(75, 0, 0, 0, 1);
        run_txn(45, 0, 1, 0, 0);
        run_txn(40, 0, 0, 1, 0);
        // abort after the second quarter pulse (cycle 6)
        @(negedge clock);
        start = 1'b1; amount = 32'd100;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            start = 1'b0;
            check("abort coins", {coin_quarter, coin_dime, coin_nickel}, {c == 2 || c == 6, 2'b00});
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check_all_zero("abort");
            @(negedge clock);
        end
        for (int i = 0; i < 30; i++)
            run_txn($urandom_range(0, 200), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
